glitch_sequencer: RTL and testbench

//  Top-level timing controller of one glitch attempt; sits directly upstream of glitch_reset.
//  On a start pulse it asserts glitch_reset's en for one cycle, then waits out the target reset.
//  It then counts a programmable delay and drives a glitch pulse of programmable width.

---
 rtl/glitch_sequencer_pkg.sv | 16 +
 rtl/glitch_counter.sv | 39 +++
 rtl/glitch_sequencer.sv | 126 ++++++++++++
 tb/tb_glitch_sequencer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/glitch_sequencer_pkg.sv
// Shared definitions for the glitch sequencer: state encodings and the
// default downstream reset length (must match glitch_reset's reset length).
package glitch_sequencer_pkg;

    localparam int GLITCH_SEQ_RESET_TIME = 32;

    typedef enum logic [2:0] {
        GLITCH_SEQ_IDLE   = 3'd0,
        GLITCH_SEQ_RESET  = 3'd1,
        GLITCH_SEQ_WAIT   = 3'd2,
        GLITCH_SEQ_DELAY  = 3'd3,
        GLITCH_SEQ_GLITCH = 3'd4,
        GLITCH_SEQ_DONE   = 3'd5
    } glitch_seq_state_e;

endpackage

// File: rtl/glitch_counter.sv
// Phase counter: clear/enable controlled, saturating up-count, terminal-count
// flag when the count has reached target-1 (i.e. the last cycle of the phase).
module glitch_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] target,
    output logic             tc
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear wins, otherwise advance and hold at all-ones.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Zero-length phases are skipped by the FSM, so target is never 0 here.
    assign tc = (count_q == (target - WIDTH'(1)));

endmodule

// File: rtl/glitch_sequencer.sv
// Timing controller for one glitch attempt.
//
//   state  | meaning
//   IDLE   | waiting for start; operands latched on accept
//   RESET  | one-cycle rst_en pulse to glitch_reset
//   WAIT   | RESET_TIME cycles while the target is held in reset
//   DELAY  | programmed delay after reset release
//   GLITCH | glitch_o high for the programmed width
//   DONE   | one-cycle done pulse, then back to IDLE
module glitch_sequencer
    import glitch_sequencer_pkg::*;
#(
    parameter int RESET_TIME = GLITCH_SEQ_RESET_TIME,
    parameter int DELAY_W    = 32,
    parameter int WIDTH_W    = 16
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               start,
    input  logic [DELAY_W-1:0] delay,
    input  logic [WIDTH_W-1:0] width,
    output logic               rst_en,
    output logic               glitch_o,
    output logic               busy,
    output logic               done
);

    glitch_seq_state_e  state_q, state_d;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic [WIDTH_W-1:0] width_q, width_d;
    logic               rst_en_q, glitch_q, busy_q, done_q;
    logic               cnt_clear, cnt_enable, cnt_tc;
    logic [DELAY_W-1:0] cnt_target;

    // Next state, operand latching and counter control.
    always_comb begin
        state_d    = state_q;
        delay_d    = delay_q;
        width_d    = width_q;
        cnt_clear  = 1'b1;
        cnt_enable = 1'b0;
        cnt_target = DELAY_W'(RESET_TIME);
        unique case (state_q)
            GLITCH_SEQ_IDLE: begin
                if (start) begin
                    delay_d = delay;
                    width_d = width;
                    state_d = GLITCH_SEQ_RESET;
                end
            end
            GLITCH_SEQ_RESET: begin
                state_d = GLITCH_SEQ_WAIT;
            end
            GLITCH_SEQ_WAIT: begin
                cnt_enable = 1'b1;
                cnt_clear  = cnt_tc;
                if (cnt_tc) begin
                    if (delay_q != '0)      state_d = GLITCH_SEQ_DELAY;
                    else if (width_q != '0) state_d = GLITCH_SEQ_GLITCH;
                    else                    state_d = GLITCH_SEQ_DONE;
                end
            end
            GLITCH_SEQ_DELAY: begin
                cnt_target = delay_q;
                cnt_enable = 1'b1;
                cnt_clear  = cnt_tc;
                if (cnt_tc) begin
                    state_d = (width_q != '0) ? GLITCH_SEQ_GLITCH : GLITCH_SEQ_DONE;
                end
            end
            GLITCH_SEQ_GLITCH: begin
                cnt_target = DELAY_W'(width_q);
                cnt_enable = 1'b1;
                cnt_clear  = cnt_tc;
                if (cnt_tc) begin
                    state_d = GLITCH_SEQ_DONE;
                end
            end
            GLITCH_SEQ_DONE: begin
                state_d = GLITCH_SEQ_IDLE;
            end
            default: begin
                state_d = GLITCH_SEQ_IDLE;
            end
        endcase
    end

    // State, operands and outputs; outputs are decoded from the next state so
    // they are registered yet line up with the state they describe.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q  <= GLITCH_SEQ_IDLE;
            delay_q  <= '0;
            width_q  <= '0;
            rst_en_q <= 1'b0;
            glitch_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            delay_q  <= delay_d;
            width_q  <= width_d;
            rst_en_q <= (state_d == GLITCH_SEQ_RESET);
            glitch_q <= (state_d == GLITCH_SEQ_GLITCH);
            busy_q   <= (state_d != GLITCH_SEQ_IDLE);
            done_q   <= (state_d == GLITCH_SEQ_DONE);
        end
    end

    glitch_counter #(
        .WIDTH (DELAY_W)
    ) u_counter (
        .clk_in (clk_in),
        .rst    (rst),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .target (cnt_target),
        .tc     (cnt_tc)
    );

    assign rst_en   = rst_en_q;
    assign glitch_o = glitch_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Bench for glitch_sequencer: directed scenarios followed by random traffic,
// checked by an event scoreboard fed from a timeline reference model.
module tb_glitch_sequencer;

    localparam int RT = 32;

    logic        clk_in = 1'b0;
    logic        rst    = 1'b1;
    logic        start  = 1'b0;
    logic [31:0] delay  = '0;
    logic [15:0] width  = '0;
    logic        rst_en, glitch_o, busy, done;

    glitch_sequencer #(.RESET_TIME(RT), .DELAY_W(32), .WIDTH_W(16)) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .start    (start),
        .delay    (delay),
        .width    (width),
        .rst_en   (rst_en),
        .glitch_o (glitch_o),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Expected output events: kind 0 = rst_en, 1 = glitch_o, 2 = done.
    typedef struct {
        int cyc;
        int kind;
    } ev_t;
    ev_t ev_q[$];

    int tests = 0;
    int fails = 0;
    int busy_lo = 1;
    int busy_hi = 0;
    int rst_o_until = -1;
    int n_accept = 0;
    logic [2:0] obs;
    logic       exp_busy;

    // Reference model: an attempt accepted in cycle c occupies a fixed timeline.
    task automatic step(input logic s, input int d, input int w, input logic r);
        int c;
        c = cyc;
        start = s;
        delay = d;
        width = 16'(w);
        rst   = r;
        if (r) begin
            while (ev_q.size() > 0 && ev_q[$].cyc > c) void'(ev_q.pop_back());
            if (busy_hi > c) busy_hi = c;
        end else if (s && c > busy_hi) begin
            n_accept++;
            busy_lo = c + 1;
            busy_hi = c + RT + 2 + d + w;
            ev_q.push_back('{c + 1, 0});
            for (int i = 0; i < w; i++) ev_q.push_back('{c + RT + 2 + d + i, 1});
            ev_q.push_back('{c + RT + 2 + d + w, 2});
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, $urandom_range(0, 50), $urandom_range(0, 9), 1'b0);
    endtask

    // Monitor: pops scoreboard entries as the DUT presents pulses.
    always @(negedge clk_in) begin
        if (cyc > 0) begin
            while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
                tests++;
                fails++;
                $display("FAIL missed_event kind=%0d expected_cycle=%0d actual=absent (now %0d)",
                         ev_q[0].kind, ev_q[0].cyc, cyc);
                void'(ev_q.pop_front());
            end
            obs = {done, glitch_o, rst_en};
            for (int k = 0; k < 3; k++) begin
                if (obs[k]) begin
                    tests++;
                    if (ev_q.size() > 0 && ev_q[0].cyc == cyc && ev_q[0].kind == k) begin
                        void'(ev_q.pop_front());
                    end else begin
                        fails++;
                        $display("FAIL unexpected_event kind=%0d cycle=%0d actual=1 required=0", k, cyc);
                    end
                end
            end
            exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
            tests++;
            if (busy !== exp_busy) begin
                fails++;
                $display("FAIL busy cycle=%0d actual=%b required=%b", cyc, busy, exp_busy);
            end
            tests++;
            if (rst_en && glitch_o) begin
                fails++;
                $display("FAIL exclusive cycle=%0d rst_en=1 glitch_o=1 required not both", cyc);
            end
            // Downstream glitch_reset holds its rst_o for RT cycles after en.
            if (glitch_o) begin
                tests++;
                if (cyc <= rst_o_until) begin
                    fails++;
                    $display("FAIL glitch_during_target_reset cycle=%0d rst_o_until=%0d", cyc, rst_o_until);
                end
            end
            if (rst_en) rst_o_until = cyc + RT;
        end
    end

    int c0;
    int acc_before;

    initial begin
        step(1'b0, 0, 0, 1'b1);
        step(1'b0, 0, 0, 1'b1);
        tests++;
        if ({rst_en, glitch_o, busy, done} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_state actual=%b required=0000", {rst_en, glitch_o, busy, done});
        end
        step(1'b0, 0, 0, 1'b1);
        idle(3);

        // 1. basic
        step(1'b1, 5, 3, 1'b0); idle(50);
        // 2. zero delay
        step(1'b1, 0, 1, 1'b0); idle(45);
        // 3. zero width
        step(1'b1, 4, 0, 1'b0); idle(45);
        // 4. start while busy, with operands changing mid-attempt
        acc_before = n_accept;
        step(1'b1, 5, 3, 1'b0); idle(19);
        step(1'b1, 9, 7, 1'b0); idle(40);
        tests++;
        if (n_accept - acc_before != 1) begin
            fails++;
            $display("FAIL busy_start_accepts actual=%0d required=1", n_accept - acc_before);
        end
        // 5. reset mid-glitch then fresh start
        c0 = cyc;
        step(1'b1, 5, 3, 1'b0); idle(39);
        step(1'b0, 0, 0, 1'b1); idle(4);
        tests++;
        if (cyc != c0 + 45) begin
            fails++;
            $display("FAIL t5_timing actual=%0d required=%0d", cyc - c0, 45);
        end
        step(1'b1, 5, 3, 1'b0); idle(50);
        // 6. back-to-back with start held
        for (int i = 0; i < 90; i++) step(1'b1, 2, 2, 1'b0);
        idle(45);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) == 0, $urandom_range(0, 12), $urandom_range(0, 6),
                 $urandom_range(0, 199) == 0);
        end
        step(1'b0, 0, 0, 1'b0);
        idle(60);
        tests++;
        if (ev_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drained actual=%0d required=0", ev_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
